// File: rtl/gcd_initiator.sv
// gcd_initiator
//   Request-side controller for the Go/Done GCD engine. It takes operand pairs
//   from an upstream valid/ready stream, drives the engine's X/Y/Go inputs,
//   waits for Done and returns result A on a downstream valid/ready stream.
//   Pairs with a zero operand never reach the engine. If the engine hangs, a
//   watchdog turns the transaction into an error response.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand pair handshake, in_x/in_y operands
//   X, Y, Go                 engine operands (registered) and level start/hold
//   Done, A                  engine result valid (level) and result
//   out_valid/out_ready      response handshake
//   out_gcd, out_x, out_y    result and the operands it belongs to
//   out_err                  watchdog timeout, or both operands zero
//   busy                     controller is not idle
//   count                    responses accepted downstream (wraps)
module gcd_initiator #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             Go,
  input  logic             Done,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Last watchdog value while Go is high; Go is high for exactly TIMEOUT cycles.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

  state_t          state;
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Go        <= 1'b0;
      X         <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      wd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            X        <= in_x;
            Y        <= in_y;
            out_x    <= in_x;
            out_y    <= in_y;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_x != '0 && in_y != '0) begin
              state <= ISSUE;
              // After a reset mid-transaction the engine may still be holding
              // a stale Done. Go is only raised once Done has been seen low;
              // otherwise ISSUE waits with Go low until Done drops.
              Go    <= !Done;
              wd    <= '0;
            end else begin
              // Zero bypass: gcd(0,v) = v, and gcd(0,0) is reported as an error.
              state     <= RESP;
              out_valid <= 1'b1;
              out_gcd   <= (in_x == '0) ? in_y : in_x;
              out_err   <= (in_x == '0) && (in_y == '0);
            end
          end
        end

        ISSUE: begin
          if (!Go) begin
            // Waiting out a stale Done left over from before a reset.
            if (!Done) begin
              Go <= 1'b1;
              wd <= '0;
            end
          end else if (Done) begin
            Go        <= 1'b0;
            out_gcd   <= A;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESP;
          end else if (wd == WD_LAST) begin
            Go        <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end

        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= count + CNT_W'(1);
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          // The engine must show Done low with Go low before the next issue.
          if (!Done) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          Go        <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
